// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the RV32I pipeline hazard controller:
//   - forwarding select codes driven onto the EX operand muxes
//   - WB result-select codes as seen in the EX stage
//   - memory wait FSM state encoding
//   - small helpers used by the forwarding and load-use logic
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

   // EX operand mux selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // WB result-select codes carried down the pipe
   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_U   = 2'b11;

   // Memory wait FSM states
   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } waitState_t;

   // True when a writing stage targets the given source register.
   // x0 is hardwired to zero, so it never produces a hazard.
   function automatic logic regHit(input logic we, input logic [4:0] rd,
                                   input logic [4:0] rs);
      return we && (rd != 5'd0) && (rd == rs);
   endfunction

   // EX operand select; the MEM stage holds the younger value, so it wins.
   function automatic logic [1:0] fwdSel(input logic weM, input logic [4:0] rdM,
                                         input logic weW, input logic [4:0] rdW,
                                         input logic [4:0] rs);
      logic [1:0] sel;
      sel = FWD_RF;
      if (regHit(weM, rdM, rs))
         sel = FWD_MEM;
      else if (regHit(weW, rdW, rs))
         sel = FWD_WB;
      return sel;
   endfunction

   // Only loads deliver their value late enough to need a stall.
   function automatic logic isLoad(input logic [1:0] resultSrc);
      logic load;
      case (resultSrc)
         RES_MEM:                  load = 1'b1;
         RES_ALU, RES_PC4, RES_U:  load = 1'b0;
         default:                  load = 1'b0;
      endcase
      return load;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_fsm.sv
// ---------------------------------------------------------------------------
// mem_wait_fsm
// Tracks a multicycle data-memory access from the MEM stage and tells the
// hazard controller when the pipeline has to be frozen.
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous reset, active-low
//   i_mreq_m     MEM-stage instruction accesses data memory
//   i_mem_ack    access complete (used when USE_ACK != 0)
//   o_mem_busy   access still outstanding this cycle (combinational)
//   o_mem_err    sticky timeout flag
// ---------------------------------------------------------------------------
module mem_wait_fsm
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int USE_ACK = 1,
   parameter int MEM_LAT = 2,
   parameter int TIMEOUT = 255
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_mreq_m,
   input  logic i_mem_ack,
   output logic o_mem_busy,
   output logic o_mem_err
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAT_C = CW'(MEM_LAT);
   localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);

   waitState_t    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_memErr;
   logic          w_done;
   logic          w_timeoutNow;

   // Completion: either the memory acknowledges, or the fixed latency has
   // elapsed. In fixed mode a zero latency completes in the request cycle.
   always_comb begin
      w_done = 1'b0;
      if (USE_ACK != 0)
         w_done = i_mem_ack;
      else if (r_state == S_IDLE)
         w_done = (MEM_LAT == 0);
      else
         w_done = (r_cnt == LAT_C);
   end

   // The timeout cycle itself no longer freezes the pipe, so the abort and
   // the stall release land in the same cycle.
   assign w_timeoutNow = (r_state == S_WAIT) && (r_cnt == TO_C) && !w_done;
   assign o_mem_busy   = i_mreq_m && !w_done && !w_timeoutNow;
   assign o_mem_err    = r_memErr;

   // Wait sequencing: the counter numbers the wait cycles starting at 1 in
   // the first WAIT cycle; the error flag only clears on reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_memErr <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_mreq_m && !w_done) begin
                  r_state <= S_WAIT;
                  r_cnt   <= CW'(1);
               end
            end
            S_WAIT: begin
               if (w_done) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else if (w_timeoutNow) begin
                  r_state  <= S_IDLE;
                  r_cnt    <= '0;
                  r_memErr <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-low reset
//   i_rs1_d, i_rs2_d                  source regs of the instruction in ID
//   i_rs1_e, i_rs2_e, i_rd_e          source/dest regs in EX
//   i_result_src_e                    WB select of the EX instruction
//   i_rd_m, i_reg_write_m             MEM-stage destination / write enable
//   i_rd_w, i_reg_write_w             WB-stage destination / write enable
//   i_pc_src_e                        taken branch or jump resolved in EX
//   i_mreq_m, i_mem_ack               data-memory request / completion
//   o_stall_f..o_stall_w              hold PC / pipeline registers
//   o_flush_d, o_flush_e              bubble IfId / IdEx
//   o_fwd_a_e, o_fwd_b_e              EX operand forwarding selects
//   o_fwd_a_d, o_fwd_b_d              ID register-file bypass from WB
//   o_mreq_out, o_mem_busy, o_mem_err data-memory request, freeze, timeout
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int USE_ACK = 1,
   parameter int MEM_LAT = 2,
   parameter int TIMEOUT = 255
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [4:0] i_rs1_d,
   input  logic [4:0] i_rs2_d,
   input  logic [4:0] i_rs1_e,
   input  logic [4:0] i_rs2_e,
   input  logic [4:0] i_rd_e,
   input  logic [1:0] i_result_src_e,
   input  logic [4:0] i_rd_m,
   input  logic       i_reg_write_m,
   input  logic [4:0] i_rd_w,
   input  logic       i_reg_write_w,
   input  logic       i_pc_src_e,
   input  logic       i_mreq_m,
   input  logic       i_mem_ack,
   output logic       o_stall_f,
   output logic       o_stall_d,
   output logic       o_stall_e,
   output logic       o_stall_m,
   output logic       o_stall_w,
   output logic       o_flush_d,
   output logic       o_flush_e,
   output logic [1:0] o_fwd_a_e,
   output logic [1:0] o_fwd_b_e,
   output logic       o_fwd_a_d,
   output logic       o_fwd_b_d,
   output logic       o_mreq_out,
   output logic       o_mem_busy,
   output logic       o_mem_err
);

   logic w_busy;
   logic w_loadUse;

   mem_wait_fsm #(
      .USE_ACK (USE_ACK),
      .MEM_LAT (MEM_LAT),
      .TIMEOUT (TIMEOUT)
   ) u_memWait (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_mreq_m   (i_mreq_m),
      .i_mem_ack  (i_mem_ack),
      .o_mem_busy (w_busy),
      .o_mem_err  (o_mem_err)
   );

   // A load in EX whose destination is read by the instruction in ID cannot
   // be forwarded in time; that pair needs a one-cycle bubble.
   assign w_loadUse = isLoad(i_result_src_e) && (i_rd_e != 5'd0) &&
                      ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));

   // Stall/flush priority: reset forces a clean bubbled pipe, then the memory
   // freeze, then a control redirect (which squashes any load-use pair), then
   // load-use. While frozen nothing is flushed, so a redirect held in EX is
   // simply acted on once the access completes.
   always_comb begin
      o_stall_f  = 1'b0;
      o_stall_d  = 1'b0;
      o_stall_e  = 1'b0;
      o_stall_m  = 1'b0;
      o_stall_w  = 1'b0;
      o_flush_d  = 1'b0;
      o_flush_e  = 1'b0;
      o_fwd_a_e  = FWD_RF;
      o_fwd_b_e  = FWD_RF;
      o_fwd_a_d  = 1'b0;
      o_fwd_b_d  = 1'b0;
      o_mreq_out = 1'b0;
      o_mem_busy = 1'b0;
      if (!i_rst) begin
         o_flush_d = 1'b1;
         o_flush_e = 1'b1;
      end else begin
         o_fwd_a_e  = fwdSel(i_reg_write_m, i_rd_m, i_reg_write_w, i_rd_w, i_rs1_e);
         o_fwd_b_e  = fwdSel(i_reg_write_m, i_rd_m, i_reg_write_w, i_rd_w, i_rs2_e);
         o_fwd_a_d  = regHit(i_reg_write_w, i_rd_w, i_rs1_d);
         o_fwd_b_d  = regHit(i_reg_write_w, i_rd_w, i_rs2_d);
         o_mreq_out = i_mreq_m;
         o_mem_busy = w_busy;
         if (w_busy) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_stall_e = 1'b1;
            o_stall_m = 1'b1;
            o_stall_w = 1'b1;
         end else if (i_pc_src_e) begin
            o_flush_d = 1'b1;
            o_flush_e = 1'b1;
         end else if (w_loadUse) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_flush_e = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for the hazard controller. The main instance waits on an
// acknowledge with an 8-cycle timeout; a second instance shares all inputs
// and runs in fixed-latency mode (2 cycles).
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic [1:0] resultSrcE;
   logic       regWriteM, regWriteW, pcSrcE, mreqM, memAck;

   logic       stallF, stallD, stallE, stallM, stallW, flushD, flushE;
   logic [1:0] fwdAE, fwdBE;
   logic       fwdAD, fwdBD, mreqOut, memBusy, memErr;

   logic       lStallF, lStallD, lStallE, lStallM, lStallW, lFlushD, lFlushE;
   logic [1:0] lFwdAE, lFwdBE;
   logic       lFwdAD, lFwdBD, lMreqOut, lMemBusy, lMemErr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.USE_ACK(1), .MEM_LAT(2), .TIMEOUT(8)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_rs1_d(rs1D), .i_rs2_d(rs2D), .i_rs1_e(rs1E), .i_rs2_e(rs2E),
      .i_rd_e(rdE), .i_result_src_e(resultSrcE),
      .i_rd_m(rdM), .i_reg_write_m(regWriteM),
      .i_rd_w(rdW), .i_reg_write_w(regWriteW),
      .i_pc_src_e(pcSrcE), .i_mreq_m(mreqM), .i_mem_ack(memAck),
      .o_stall_f(stallF), .o_stall_d(stallD), .o_stall_e(stallE),
      .o_stall_m(stallM), .o_stall_w(stallW),
      .o_flush_d(flushD), .o_flush_e(flushE),
      .o_fwd_a_e(fwdAE), .o_fwd_b_e(fwdBE), .o_fwd_a_d(fwdAD), .o_fwd_b_d(fwdBD),
      .o_mreq_out(mreqOut), .o_mem_busy(memBusy), .o_mem_err(memErr)
   );

   pipe_hazard_ctrl #(.USE_ACK(0), .MEM_LAT(2), .TIMEOUT(8)) u_dutLat (
      .i_clk(clk), .i_rst(rst),
      .i_rs1_d(rs1D), .i_rs2_d(rs2D), .i_rs1_e(rs1E), .i_rs2_e(rs2E),
      .i_rd_e(rdE), .i_result_src_e(resultSrcE),
      .i_rd_m(rdM), .i_reg_write_m(regWriteM),
      .i_rd_w(rdW), .i_reg_write_w(regWriteW),
      .i_pc_src_e(pcSrcE), .i_mreq_m(mreqM), .i_mem_ack(memAck),
      .o_stall_f(lStallF), .o_stall_d(lStallD), .o_stall_e(lStallE),
      .o_stall_m(lStallM), .o_stall_w(lStallW),
      .o_flush_d(lFlushD), .o_flush_e(lFlushE),
      .o_fwd_a_e(lFwdAE), .o_fwd_b_e(lFwdBE), .o_fwd_a_d(lFwdAD), .o_fwd_b_d(lFwdBD),
      .o_mreq_out(lMreqOut), .o_mem_busy(lMemBusy), .o_mem_err(lMemErr)
   );

   // Advance to just after the next rising edge; inputs are then changed
   // and outputs sampled a further #1 later, well away from either edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Return every pipeline input to a quiet, hazard-free value.
   task automatic applyStimulus();
      rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
      rdE = 5'd0; rdM = 5'd0; rdW = 5'd0; resultSrcE = 2'b00;
      regWriteM = 1'b0; regWriteW = 1'b0; pcSrcE = 1'b0;
      mreqM = 1'b0; memAck = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      applyStimulus();
      tick();
      // Inputs that would otherwise forward, stall and request memory
      rdM = 5'd5; regWriteM = 1'b1; rs1E = 5'd5; rdW = 5'd6; regWriteW = 1'b1;
      rs1D = 5'd6; mreqM = 1'b1; resultSrcE = 2'b01; rdE = 5'd3; rs2D = 5'd3;
      #1;
      checks++; if (stallF !== 1'b0) begin failures++; $display("[TB] FAIL rst_stall_f got=%b exp=0", stallF); end
      checks++; if (stallW !== 1'b0) begin failures++; $display("[TB] FAIL rst_stall_w got=%b exp=0", stallW); end
      checks++; if ({flushD, flushE} !== 2'b11) begin failures++; $display("[TB] FAIL rst_flush got=%b exp=11", {flushD, flushE}); end
      checks++; if (fwdAE !== 2'b00) begin failures++; $display("[TB] FAIL rst_fwd_a_e got=%b exp=00", fwdAE); end
      checks++; if (fwdAD !== 1'b0) begin failures++; $display("[TB] FAIL rst_fwd_a_d got=%b exp=0", fwdAD); end
      checks++; if (mreqOut !== 1'b0) begin failures++; $display("[TB] FAIL rst_mreq_out got=%b exp=0", mreqOut); end
      checks++; if (memErr !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem_err got=%b exp=0", memErr); end
      applyStimulus();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_forwarding();
      rdM = 5'd5; regWriteM = 1'b1; rs1E = 5'd5; rdW = 5'd5; regWriteW = 1'b1;
      #1;
      checks++; if (fwdAE !== 2'b10) begin failures++; $display("[TB] FAIL fwd_a_mem got=%b exp=10", fwdAE); end
      rdM = 5'd0; #1;
      checks++; if (fwdAE !== 2'b01) begin failures++; $display("[TB] FAIL fwd_a_wb got=%b exp=01", fwdAE); end
      rs1E = 5'd0; #1;
      checks++; if (fwdAE !== 2'b00) begin failures++; $display("[TB] FAIL fwd_a_x0 got=%b exp=00", fwdAE); end
      rs2E = 5'd7; rdM = 5'd7; rdW = 5'd7; #1;
      checks++; if (fwdBE !== 2'b10) begin failures++; $display("[TB] FAIL fwd_b_mem got=%b exp=10", fwdBE); end
      regWriteM = 1'b0; #1;
      checks++; if (fwdBE !== 2'b01) begin failures++; $display("[TB] FAIL fwd_b_wb got=%b exp=01", fwdBE); end
      rs1D = 5'd7; rs2D = 5'd9; #1;
      checks++; if ({fwdAD, fwdBD} !== 2'b10) begin failures++; $display("[TB] FAIL fwd_d_a got=%b exp=10", {fwdAD, fwdBD}); end
      rdW = 5'd9; #1;
      checks++; if ({fwdAD, fwdBD} !== 2'b01) begin failures++; $display("[TB] FAIL fwd_d_b got=%b exp=01", {fwdAD, fwdBD}); end
      regWriteW = 1'b0; #1;
      checks++; if ({fwdAD, fwdBD, fwdBE} !== 4'b0000) begin failures++; $display("[TB] FAIL fwd_no_we got=%b exp=0000", {fwdAD, fwdBD, fwdBE}); end
      applyStimulus();
      tick();
   endtask

   task automatic test_load_use();
      resultSrcE = 2'b01; rdE = 5'd3; rs2D = 5'd3; #1;
      checks++; if ({stallF, stallD, flushE} !== 3'b111) begin failures++; $display("[TB] FAIL lu_stall got=%b exp=111", {stallF, stallD, flushE}); end
      checks++; if ({flushD, stallE, stallM} !== 3'b000) begin failures++; $display("[TB] FAIL lu_others got=%b exp=000", {flushD, stallE, stallM}); end
      // The bubble now sits in EX
      tick();
      resultSrcE = 2'b00; rdE = 5'd0; #1;
      checks++; if ({stallF, stallD, flushE} !== 3'b000) begin failures++; $display("[TB] FAIL lu_release got=%b exp=000", {stallF, stallD, flushE}); end
      resultSrcE = 2'b01; rdE = 5'd0; rs1D = 5'd0; #1;
      checks++; if ({stallF, stallD, flushE} !== 3'b000) begin failures++; $display("[TB] FAIL lu_rd_x0 got=%b exp=000", {stallF, stallD, flushE}); end
      resultSrcE = 2'b00; rdE = 5'd3; #1;
      checks++; if ({stallF, stallD, flushE} !== 3'b000) begin failures++; $display("[TB] FAIL lu_not_load got=%b exp=000", {stallF, stallD, flushE}); end
      applyStimulus();
      tick();
   endtask

   task automatic test_redirect();
      resultSrcE = 2'b01; rdE = 5'd3; rs2D = 5'd3; pcSrcE = 1'b1; #1;
      checks++; if ({flushD, flushE} !== 2'b11) begin failures++; $display("[TB] FAIL redir_flush got=%b exp=11", {flushD, flushE}); end
      checks++; if ({stallF, stallD} !== 2'b00) begin failures++; $display("[TB] FAIL redir_stall got=%b exp=00", {stallF, stallD}); end
      applyStimulus();
      tick();
   endtask

   task automatic test_mem_ack();
      mreqM = 1'b1; pcSrcE = 1'b1; #1;
      checks++; if ({memBusy, stallF, stallD, stallE, stallM, stallW} !== 6'b111111) begin failures++; $display("[TB] FAIL ack_c1_stall got=%b exp=111111", {memBusy, stallF, stallD, stallE, stallM, stallW}); end
      checks++; if ({flushD, flushE} !== 2'b00) begin failures++; $display("[TB] FAIL ack_c1_flush got=%b exp=00", {flushD, flushE}); end
      checks++; if (mreqOut !== 1'b1) begin failures++; $display("[TB] FAIL ack_mreq_out got=%b exp=1", mreqOut); end
      tick(); #1;
      checks++; if ({stallF, stallW, flushD} !== 3'b110) begin failures++; $display("[TB] FAIL ack_c2 got=%b exp=110", {stallF, stallW, flushD}); end
      tick();
      memAck = 1'b1; #1;
      checks++; if ({memBusy, stallF, stallM, stallW} !== 4'b0000) begin failures++; $display("[TB] FAIL ack_c3_release got=%b exp=0000", {memBusy, stallF, stallM, stallW}); end
      checks++; if ({flushD, flushE} !== 2'b11) begin failures++; $display("[TB] FAIL ack_c3_redirect got=%b exp=11", {flushD, flushE}); end
      tick();
      applyStimulus();
      memAck = 1'b1; #1;
      checks++; if ({memBusy, stallF} !== 2'b00) begin failures++; $display("[TB] FAIL ack_idle_ignored got=%b exp=00", {memBusy, stallF}); end
      tick();
      mreqM = 1'b1; memAck = 1'b1; #1;
      checks++; if ({memBusy, stallF} !== 2'b00) begin failures++; $display("[TB] FAIL ack_same_cycle got=%b exp=00", {memBusy, stallF}); end
      tick();
      applyStimulus();
      tick();
   endtask

   // Wait state entered from IDLE: 8 busy cycles, then the abort cycle.
   task automatic test_timeout();
      int busyCount;
      busyCount = 0;
      mreqM = 1'b1; #1;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) tick();
         #1;
         checks++; if ({memBusy, stallW} !== 2'b11) begin failures++; busyCount++; $display("[TB] FAIL to_busy_c%0d got=%b exp=11", k, {memBusy, stallW}); end
      end
      tick(); #1;
      checks++; if ({memBusy, stallF, mreqOut, memErr} !== 4'b0010) begin failures++; $display("[TB] FAIL to_release got=%b exp=0010", {memBusy, stallF, mreqOut, memErr}); end
      tick();
      mreqM = 1'b0; #1;
      checks++; if (memErr !== 1'b1) begin failures++; $display("[TB] FAIL to_err_set got=%b exp=1", memErr); end
      tick(); tick(); tick(); #1;
      checks++; if ({memErr, memBusy} !== 2'b10) begin failures++; $display("[TB] FAIL to_err_sticky got=%b exp=10", {memErr, memBusy}); end
      if (busyCount != 0) $display("[TB] timeout busy window short by %0d", busyCount);
   endtask

   task automatic test_reset_mid_wait();
      mreqM = 1'b1;
      tick(); tick(); tick(); tick();
      // Now in WAIT with cnt=4
      rst = 1'b0; #1;
      checks++; if ({stallF, stallM, flushD, flushE, mreqOut} !== 5'b00110) begin failures++; $display("[TB] FAIL rmid_forced got=%b exp=00110", {stallF, stallM, flushD, flushE, mreqOut}); end
      tick();
      rst = 1'b1; #1;
      checks++; if (memErr !== 1'b0) begin failures++; $display("[TB] FAIL rmid_err_clr got=%b exp=0", memErr); end
      // Counter restarted from IDLE: full 8-cycle window again
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) tick();
         #1;
         checks++; if (memBusy !== 1'b1) begin failures++; $display("[TB] FAIL rmid_busy_c%0d got=%b exp=1", k, memBusy); end
      end
      tick(); #1;
      checks++; if (memBusy !== 1'b0) begin failures++; $display("[TB] FAIL rmid_release got=%b exp=0", memBusy); end
      tick();
      mreqM = 1'b0; #1;
      checks++; if (memErr !== 1'b1) begin failures++; $display("[TB] FAIL rmid_err_again got=%b exp=1", memErr); end
      tick();
   endtask

   task automatic test_fixed_latency();
      rst = 1'b0; applyStimulus();
      tick();
      rst = 1'b1; mreqM = 1'b1; #1;
      checks++; if ({lMemBusy, lStallF} !== 2'b11) begin failures++; $display("[TB] FAIL lat_c1 got=%b exp=11", {lMemBusy, lStallF}); end
      tick(); #1;
      checks++; if ({lMemBusy, lStallW} !== 2'b11) begin failures++; $display("[TB] FAIL lat_c2 got=%b exp=11", {lMemBusy, lStallW}); end
      tick(); #1;
      checks++; if ({lMemBusy, lStallF, lMemErr} !== 3'b000) begin failures++; $display("[TB] FAIL lat_c3 got=%b exp=000", {lMemBusy, lStallF, lMemErr}); end
      tick();
      mreqM = 1'b0; #1;
      checks++; if (lMemBusy !== 1'b0) begin failures++; $display("[TB] FAIL lat_idle got=%b exp=0", lMemBusy); end
      tick();
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_redirect();
      test_mem_ack();
      test_timeout();
      test_reset_mid_wait();
      test_fixed_latency();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
